// File: rtl/fft_r22sdf_ctrl.sv
// fft_r22sdf_ctrl: sequencing controller for a streaming radix-2^2 SDF FFT.
// Tracks the sample position entering every BF I/BF II stage pair, drives
// butterfly selects, BF II -j swap flags and twiddle ROM addresses, gates
// input acceptance and marks the output frame. Touches no sample data.
// Ports:
//   clk_i, rst_n      clock, synchronous active-low reset
//   valid_i           input sample present
//   ready_o           sample accepted this cycle
//   zero_o            datapath substitutes 0 for the input (abort padding)
//   bfi_sel_o         BF I select per stage
//   bfii_sel_o        BF II select per stage
//   bfii_negj_o       BF II -j swap enable per stage
//   tw_addr_o         twiddle address per stage (slice s = stage s)
//   valid_o, idx_o    output sample valid and natural position in frame
//   frame_done_o      pulse with the last output sample of a frame
//   err_o             pulse when valid_i drops mid-frame
module fft_r22sdf_ctrl #(
  parameter int unsigned N         = 1024,
  parameter int unsigned LOG2N     = 10,
  parameter int unsigned STAGE_LAT = 1,
  localparam int unsigned NSTAGES  = LOG2N / 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic                       zero_o,
  output logic [NSTAGES-1:0]         bfi_sel_o,
  output logic [NSTAGES-1:0]         bfii_sel_o,
  output logic [NSTAGES-1:0]         bfii_negj_o,
  output logic [NSTAGES*LOG2N-1:0]   tw_addr_o,
  output logic                       valid_o,
  output logic [LOG2N-1:0]           idx_o,
  output logic                       frame_done_o,
  output logic                       err_o
);

  localparam int unsigned TOTAL_LAT = N - 1 + NSTAGES * STAGE_LAT;
  localparam int unsigned LATW      = $clog2(TOTAL_LAT + 1);
  localparam int unsigned HD        = (NSTAGES - 1) * STAGE_LAT;
  localparam int unsigned HDEPTH    = (HD > 0) ? HD : 1;
  localparam int unsigned PW        = LOG2N + 2;
  localparam int unsigned NSLOT     = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [LOG2N-1:0]         c0_q, c0_d;
  logic [LOG2N-1:0]         hist_q [HDEPTH];
  logic [LOG2N-1:0]         hist_d [HDEPTH];
  logic [LOG2N-1:0]         cs_q [NSTAGES];
  logic [LOG2N-1:0]         cs_d [NSTAGES];
  logic [NSTAGES*LOG2N-1:0] tw_q, tw_d;
  logic                     ready_q, ready_d;
  logic                     zero_q, zero_d;
  logic                     valid_q, valid_d;
  logic [LOG2N-1:0]         idx_q, idx_d;
  logic                     done_q, done_d;
  logic [NSLOT-1:0]         busy_q, busy_d;
  logic [LATW-1:0]          lat_q [NSLOT];
  logic [LATW-1:0]          lat_d [NSLOT];
  logic                     start_c;
  logic                     err_c;
  logic                     fire_c;
  logic                     drained_c;
  logic                     c0_zero_c;
  logic                     c0_last_c;

  // Twiddle index: map(top two position bits) * remaining bits, scaled by stage.
  function automatic logic [LOG2N-1:0] tw_calc(input logic [LOG2N-1:0] c,
                                               input int unsigned s);
    int unsigned    sh;
    logic [1:0]     t;
    logic [1:0]     m;
    logic [LOG2N-1:0] k;
    logic [PW-1:0]  prod;
    sh = LOG2N - 2 - 2 * s;
    t  = 2'(c >> sh);
    k  = c & LOG2N'((1 << sh) - 1);
    case (t)
      2'd0:    m = 2'd0;
      2'd1:    m = 2'd2;
      2'd2:    m = 2'd1;
      default: m = 2'd3;
    endcase
    prod = PW'(m) * PW'(k);
    return LOG2N'(prod << (2 * s));
  endfunction

  assign c0_zero_c = (c0_q == '0);
  assign c0_last_c = (c0_q == LOG2N'(N - 1));
  // Nothing left to emit once no frame is waiting and the current window ends.
  assign drained_c = (busy_q == '0) && (!valid_q || (idx_q == LOG2N'(N - 1)));

  // Next-state logic; start_c marks acceptance of a frame's position 0.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_RUN;
          start_c = 1'b1;
        end
      end
      S_RUN: begin
        if (!valid_i) begin
          if (c0_zero_c) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ABORT;
            err_c   = 1'b1;
          end
        end else if (c0_zero_c) begin
          start_c = 1'b1;
        end
      end
      S_ABORT: begin
        if (c0_last_c) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (valid_i && c0_zero_c) begin
          state_d = S_RUN;
          start_c = 1'b1;
        end else if (drained_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Position counters: c_0 free-runs outside IDLE; later stages are delayed copies.
  always_comb begin
    c0_d      = (state_d != S_IDLE) ? c0_q + LOG2N'(1) : '0;
    hist_d[0] = (state_d != S_IDLE) ? c0_q : '0;
    for (int i = 1; i < HDEPTH; i++) begin
      hist_d[i] = (state_d != S_IDLE) ? hist_q[i-1] : '0;
    end
    ready_d = (state_d == S_IDLE) || (state_d == S_RUN) ||
              ((state_d == S_DRAIN) && (c0_d == '0));
    zero_d  = (state_d == S_ABORT);
  end

  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    localparam int unsigned D = s * STAGE_LAT;
    if (D == 0) begin : g_d0
      assign cs_q[s] = c0_q;
      assign cs_d[s] = c0_d;
    end else begin : g_dn
      assign cs_q[s] = hist_q[D-1];
      assign cs_d[s] = hist_d[D-1];
    end
    assign bfi_sel_o[s]   = cs_q[s][LOG2N-1-2*s];
    assign bfii_sel_o[s]  = cs_q[s][LOG2N-2-2*s];
    assign bfii_negj_o[s] = cs_q[s][LOG2N-1-2*s] & ~cs_q[s][LOG2N-2-2*s];
  end

  // Twiddle addresses computed from next positions so they align with the selects.
  always_comb begin
    tw_d = '0;
    for (int s = 0; s < NSTAGES - 1; s++) begin
      tw_d[s*LOG2N +: LOG2N] = tw_calc(cs_d[s], s);
    end
  end

  // Latency slots: each accepted frame counts down to the start of its output window.
  always_comb begin
    fire_c = 1'b0;
    busy_d = busy_q;
    for (int i = 0; i < NSLOT; i++) begin
      lat_d[i] = lat_q[i];
      if (busy_q[i]) begin
        if (lat_q[i] == '0) begin
          fire_c    = 1'b1;
          busy_d[i] = 1'b0;
        end else begin
          lat_d[i] = lat_q[i] - LATW'(1);
        end
      end
    end
    if (start_c) begin
      if (!busy_d[0]) begin
        busy_d[0] = 1'b1;
        lat_d[0]  = LATW'(TOTAL_LAT - 2);
      end else begin
        busy_d[1] = 1'b1;
        lat_d[1]  = LATW'(TOTAL_LAT - 2);
      end
    end
  end

  // Output window: a firing slot restarts idx so back-to-back frames stay contiguous.
  always_comb begin
    valid_d = fire_c || (valid_q && (idx_q != LOG2N'(N - 1)));
    if (fire_c) begin
      idx_d = '0;
    end else if (valid_d) begin
      idx_d = idx_q + LOG2N'(1);
    end else begin
      idx_d = '0;
    end
    done_d = valid_d && (idx_d == LOG2N'(N - 1));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c0_q    <= '0;
      for (int i = 0; i < HDEPTH; i++) hist_q[i] <= '0;
      tw_q    <= '0;
      ready_q <= 1'b1;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= '0;
      for (int i = 0; i < NSLOT; i++) lat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      c0_q    <= c0_d;
      for (int i = 0; i < HDEPTH; i++) hist_q[i] <= hist_d[i];
      tw_q    <= tw_d;
      ready_q <= ready_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NSLOT; i++) lat_q[i] <= lat_d[i];
    end
  end

  assign ready_o      = ready_q;
  assign zero_o       = zero_q;
  assign tw_addr_o    = tw_q;
  assign valid_o      = valid_q;
  assign idx_o        = idx_q;
  assign frame_done_o = done_q;
  // Flags the drop in the same cycle valid_i goes low.
  assign err_o        = err_c;

endmodule

// File: tb/tb_fft_r22sdf_ctrl.sv
// tb_fft_r22sdf_ctrl: directed and randomized bench for fft_r22sdf_ctrl (N=16).
// Expected values come from a time-based model: session start time, a list of
// frame start times and a receive/abort flag, evaluated with plain arithmetic.
module tb_fft_r22sdf_ctrl;

  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;
  localparam int unsigned SL    = 1;
  localparam int unsigned NS    = LOG2N / 2;
  localparam int          L     = N - 1 + NS * SL;

  logic                  clk_i = 1'b0;
  logic                  rst_n;
  logic                  valid_i;
  logic                  ready_o;
  logic                  zero_o;
  logic [NS-1:0]         bfi_sel_o;
  logic [NS-1:0]         bfii_sel_o;
  logic [NS-1:0]         bfii_negj_o;
  logic [NS*LOG2N-1:0]   tw_addr_o;
  logic                  valid_o;
  logic [LOG2N-1:0]      idx_o;
  logic                  frame_done_o;
  logic                  err_o;

  fft_r22sdf_ctrl #(.N(N), .LOG2N(LOG2N), .STAGE_LAT(SL)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .zero_o       (zero_o),
    .bfi_sel_o    (bfi_sel_o),
    .bfii_sel_o   (bfii_sel_o),
    .bfii_negj_o  (bfii_negj_o),
    .tw_addr_o    (tw_addr_o),
    .valid_o      (valid_o),
    .idx_o        (idx_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int cyc = 0;
  bit m_active = 1'b0;
  bit m_recv   = 1'b0;
  bit m_abort  = 1'b0;
  int m_base   = 0;
  int starts[$];

  function automatic int m_pos(input int s);
    int d;
    if (!m_active) return 0;
    d = cyc - m_base - s * int'(SL);
    return (d < 0) ? 0 : d % N;
  endfunction

  function automatic int m_tw(input int c, input int s);
    int sh, t, k, mp;
    sh = LOG2N - 2 - 2 * s;
    t  = (c >> sh) % 4;
    k  = c % (1 << sh);
    mp = (t == 1) ? 2 : (t == 2) ? 1 : t;
    return ((mp * k) << (2 * s)) % N;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
  endtask

  task automatic step(input logic v, input logic r);
    int c0, c, idx;
    logic e_ready, e_zero, e_err, e_valid, e_done;
    logic [NS-1:0] e_bfi, e_bfii, e_negj;
    logic [NS*LOG2N-1:0] e_tw;
    @(posedge clk_i);
    #1;
    valid_i = v;
    rst_n   = r;
    @(negedge clk_i);

    c0      = m_pos(0);
    e_ready = !m_active ? 1'b1 : m_recv ? 1'b1 : m_abort ? 1'b0 : (c0 == 0);
    e_zero  = m_abort;
    e_err   = m_recv && !v && (c0 != 0);
    e_tw    = '0;
    for (int s = 0; s < NS; s++) begin
      c         = m_pos(s);
      e_bfi[s]  = 1'((c >> (LOG2N - 1 - 2 * s)) & 1);
      e_bfii[s] = 1'((c >> (LOG2N - 2 - 2 * s)) & 1);
      e_negj[s] = e_bfi[s] & ~e_bfii[s];
      if (s < NS - 1) e_tw[s*LOG2N +: LOG2N] = LOG2N'(m_tw(c, s));
    end
    e_valid = 1'b0;
    idx     = 0;
    foreach (starts[i]) begin
      if (cyc >= starts[i] + L && cyc <= starts[i] + L + N - 1) begin
        e_valid = 1'b1;
        idx     = cyc - starts[i] - L;
      end
    end
    e_done = e_valid && (idx == N - 1);

    chk("ready_o", 64'(ready_o), 64'(e_ready));
    chk("zero_o", 64'(zero_o), 64'(e_zero));
    chk("err_o", 64'(err_o), 64'(e_err));
    chk("bfi_sel_o", 64'(bfi_sel_o), 64'(e_bfi));
    chk("bfii_sel_o", 64'(bfii_sel_o), 64'(e_bfii));
    chk("bfii_negj_o", 64'(bfii_negj_o), 64'(e_negj));
    chk("tw_addr_o", 64'(tw_addr_o), 64'(e_tw));
    chk("valid_o", 64'(valid_o), 64'(e_valid));
    chk("idx_o", 64'(idx_o), 64'(idx));
    chk("frame_done_o", 64'(frame_done_o), 64'(e_done));

    // Advance the model by the inputs sampled at the coming edge.
    if (!r) begin
      m_active = 1'b0;
      m_recv   = 1'b0;
      m_abort  = 1'b0;
      starts.delete();
    end else if (!m_active) begin
      if (v) begin
        m_active = 1'b1;
        m_base   = cyc;
        m_recv   = 1'b1;
        starts.push_back(cyc);
      end
    end else if (m_recv) begin
      if (!v) begin
        m_recv = 1'b0;
        if (c0 != 0) m_abort = 1'b1;
      end else if (c0 == 0) begin
        starts.push_back(cyc);
      end
    end else if (m_abort) begin
      if (c0 == N - 1) m_abort = 1'b0;
    end else begin
      if (v && c0 == 0) begin
        m_recv = 1'b1;
        starts.push_back(cyc);
      end else if (starts.size() == 0 || cyc >= starts[$] + L + N - 1) begin
        m_active = 1'b0;
      end
    end
    while (starts.size() > 1 && cyc > starts[0] + L + N - 1) void'(starts.pop_front());
    cyc++;
  endtask

  initial begin
    int p;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);

    // Reset state, then a single frame with drain to idle
    step(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1);

    // Three back-to-back frames
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1);

    // Drop at position 6: error, zero padding, aborted frame still emitted
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);

    // Drop at position 6 with valid_i held high again during the abort
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

    // Reset pulsed 20 cycles into a frame
    for (int i = 0; i < 36; i++) step(1'b1, (i != 20));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

    // Randomized valid density, with occasional resets
    p = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 4))
          0: p = 100;
          1: p = 98;
          2: p = 90;
          3: p = 50;
          default: p = 0;
        endcase
      end
      step(($urandom_range(0, 99) < p), ($urandom_range(0, 999) != 0));
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_r22sdf_ctrl.md
Name: fft_r22sdf_ctrl

Overview:
Sequencing controller for a streaming radix-2^2 single-path delay-feedback (R22SDF) FFT pipeline built from BF I / BF II stage pairs.
- Tracks the sample position of data entering each stage and drives the butterfly select lines, the BF II -j swap flags and the twiddle ROM addresses.
- Gates input acceptance and produces output valid, index and frame markers.
- Sits between the sample source and the butterfly/twiddle datapath; it touches no sample data.

Parameters:
N, 1024, FFT length; power of 4.
LOG2N, 10, log2(N); even.
NSTAGES, LOG2N/2, number of BF I/BF II stage pairs (derived; do not override).
STAGE_LAT, 1, pipeline register cycles per stage pair, added to the SDF delays (twiddle-multiplier registers).

Ports:
clk_i  in  1  clock
rst_n  in  1  synchronous reset, active low
valid_i  in  1  input sample present this cycle
ready_o  out  1  controller accepts a sample this cycle
zero_o  out  1  datapath must substitute 0 for the input sample (abort padding)
bfi_sel_o  out  NSTAGES  BF I select, bit s = stage s
bfii_sel_o  out  NSTAGES  BF II select, bit s = stage s
bfii_negj_o  out  NSTAGES  BF II -j swap enable, bit s = stage s
tw_addr_o  out  NSTAGES*LOG2N  twiddle address; slice s = stage s; last slice always 0
valid_o  out  1  FFT output sample valid
idx_o  out  LOG2N  output position within frame, natural count (data order is bit-reversed)
frame_done_o  out  1  one-cycle pulse with the last valid_o of a frame
err_o  out  1  one-cycle pulse when valid_i drops mid-frame

Behaviour:
- Reset (rst_n low at posedge): state IDLE; all counters 0; every output 0 except ready_o = 1.
- Reset mid-frame discards all in-flight frames; no valid_o is emitted for them.
- Per-stage counter c_s (LOG2N bits) holds the position of the sample entering stage s. It starts D_s = s*STAGE_LAT cycles after c_0 starts.
- Once started, each c_s increments every clock, wrapping N-1 -> 0, because the SDF delay lines shift every cycle. All counters hold at 0 in IDLE.
- bfi_sel_o[s] = c_s[LOG2N-1-2s].
- bfii_sel_o[s] = c_s[LOG2N-2-2s].
- bfii_negj_o[s] = c_s[LOG2N-1-2s] & ~c_s[LOG2N-2-2s].
- Twiddle, stage s < NSTAGES-1:
  - t = c_s[LOG2N-1-2s : LOG2N-2-2s], mapped 00->0, 01->2, 10->1, 11->3.
  - k = c_s[LOG2N-3-2s : 0].
  - tw_addr = (map(t) * k) << 2s, truncated to LOG2N bits.
  - Registered; valid in the same cycle as the matching sel bits, so it changes with c_s.
- State machine:
  - IDLE: ready_o = 1. valid_i = 1 -> RUN; that sample is position 0 and c_0 starts.
  - RUN: ready_o = 1. valid_i is required every cycle.
    - valid_i = 0 with c_0 != 0 -> ABORT; err_o pulses that cycle.
    - valid_i = 0 with c_0 == 0 (frame boundary) -> DRAIN.
  - ABORT: ready_o = 0, zero_o = 1. Continues until c_0 wraps to 0, then DRAIN. The aborted frame is still output, zero-padded.
  - DRAIN: ready_o = 1 only when c_0 == 0.
    - valid_i = 1 with c_0 == 0 -> RUN (back-to-back resume, no bubble).
    - After the last pending output sample -> IDLE.
- Output timing:
  - TOTAL_LAT = N-1 + NSTAGES*STAGE_LAT.
  - Input position 0 of a frame accepted at cycle T gives valid_o = 1 for cycles T+TOTAL_LAT through T+TOTAL_LAT+N-1.
  - idx_o runs 0..N-1 over that window; frame_done_o pulses when idx_o = N-1.
  - Up to 2 frames may be in flight. Back-to-back frames give continuous valid_o.
  - Outside valid windows, valid_o = 0 and idx_o = 0.
- Simultaneous events: reset has priority over everything. A valid_i drop at the frame boundary is not an error.

Test Plan:
(All with N=16, LOG2N=4, STAGE_LAT=1, so NSTAGES=2 and TOTAL_LAT=17.)
1. Reset, then hold valid_i=1 for 16 cycles starting cycle 0 -> ready_o=1 throughout; bfi_sel_o[0]=0 for cycles 0-7 and 1 for cycles 8-15; bfii_sel_o[0] toggles every 4 cycles; valid_o=1 for cycles 17-32 with idx_o 0..15; frame_done_o at cycle 32; then IDLE.
2. Twiddle check on stage 0, single frame -> c_0=5 gives tw_addr slice 0 = 2*1 = 2; c_0=9 gives 1*1 = 1; c_0=15 gives 3*3 = 9; c_0=0..3 gives 0. Slice 1 is always 0.
3. Stage delay -> c_1 = 0 at cycle 1; bfi_sel_o[1] = c_1[1] (high at cycles 3-4, 7-8, ...); bfii_negj_o[1]=1 when c_1[1:0]=10.
4. Three back-to-back frames (48 valid cycles) -> valid_o continuously high for cycles 17-64; frame_done_o at cycles 32, 48 and 64.
5. valid_i dropped at c_0=6 -> err_o pulses once; zero_o=1 and ready_o=0 until c_0 wraps; valid_o still asserted for cycles 17-32; then IDLE.
6. rst_n pulsed low at cycle 20 of scenario 1 -> from cycle 21 all outputs 0, ready_o=1, no further valid_o.
